palin_chk_sched: RTL and testbench
==================================

Name: palin_chk_sched

Overview:
Round-robin scheduler that shares one serial binary-palindrome checking engine among N requesters.
- Grants one requester at a time and latches its W-bit word.
- Streams the word MSB-first on a serial output, one bit per clock, so a downstream serial detector can observe it.
- Decides whether the word is a palindrome and reports the result tagged with the requester ID.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, word width in bits (1..32)
- ID_W, $clog2(N), width of the requester ID (localparam, derived)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  N  level request per requester; bit i = requester i
- data_in  input  N*W  requester i word at data_in[i*W +: W]; sampled only at grant
- gnt  output  N  one-hot grant; 1-cycle pulse
- busy  output  1  high in SHIFT and REPORT
- ser_out  output  1  current serial bit, MSB first
- ser_valid  output  1  ser_out valid; high for exactly W cycles per job
- done  output  1  1-cycle result strobe
- is_pal  output  1  result; valid only while done=1
- done_id  output  ID_W  requester served; valid only while done=1
- pal_count  output  8  palindrome statistics (see Optional Feature)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - All outputs = 0.
  - Shift and history registers = 0.
  - Bit counter = 0.
  - last_id = N-1, so requester 0 has first priority.
- States:
  - IDLE: busy=0, ser_valid=0. At a rising edge with req != 0:
    - Winner = first set bit searching upward from (last_id+1) mod N, wrapping.
    - Latch its word into the shift register; set last_id = winner.
    - Assert gnt[winner] for the next cycle only; go to SHIFT.
  - SHIFT: busy=1, ser_valid=1, ser_out = shift-register MSB.
    - Each edge: shift left; append the emitted bit to the history register LSB; increment the counter.
    - After the W-th edge go to REPORT.
  - REPORT (exactly 1 cycle): busy=1, done=1, done_id=last_id.
    - is_pal=1 iff history[k] == history[W-1-k] for all k; W=1 always yields is_pal=1.
    - Next edge returns to IDLE.
- Timing:
  - Grant decided at edge T.
  - gnt and the first serial bit are visible in cycle T..T+1.
  - Serial bits occupy W consecutive cycles.
  - done is high in cycle W+1 after the grant edge.
  - Minimum job period = W+2 cycles; IDLE always lasts at least 1 cycle between jobs.
- Requests:
  - req is level, not latched. Requests arriving while busy wait; they are arbitrated in IDLE.
  - req deasserted after grant does not abort the job.
  - data_in changes after grant have no effect.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0 with no requester skipped.
- Reset mid-job: job discarded immediately; no done pulse; outputs return to 0 asynchronously; priority pointer returns to requester 0.
- No combinational path from req or data_in to any output; all outputs registered.

Optional Feature:
- Macro: PALIN_CHK_STATS_EN.
- Defined: pal_count increments by 1 on each REPORT cycle with is_pal=1.
  - Saturates at 255.
  - Cleared only by rst.
  - Updated value visible the cycle after done.
- Undefined: pal_count is constant 0 and the counter logic is not built; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 15 time units with req=4'b1111 → gnt, busy, ser_valid, done, pal_count all 0; after release, first grant is gnt=4'b0001.
- Single palindrome: N=4, W=8, req=4'b0100, word2=8'b10011001 → gnt=4'b0100 for 1 cycle; ser_out sequence 1,0,0,1,1,0,0,1; done with is_pal=1, done_id=2, 9 cycles after grant edge; pal_count=1 with macro defined.
- Non-palindrome: req=4'b0001, word0=8'b10110010 → ser_out 1,0,1,1,0,0,1,0; done with is_pal=0, done_id=0; pal_count unchanged.
- Round-robin: req=4'b1111 held, all words 8'hFF → done_id sequence 0,1,2,3,0 at 10-cycle spacing; every is_pal=1.
- Reset mid-job: assert rst during the 4th SHIFT cycle → no done pulse; after release with req=4'b1010, first gnt=4'b0010.
- Withdrawn request: req=4'b1000 for exactly the grant cycle, then 0 → all 8 bits still stream; done with done_id=3; then IDLE with busy=0.

Source files
------------

// File: rtl/palin_chk_sched.sv
// Round-robin scheduler sharing one serial palindrome checker among N requesters.
// Optional palindrome statistics counter is built when PALIN_CHK_STATS_EN is defined.
module palin_chk_sched #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    data_in,
    output logic [N-1:0]      gnt,
    output logic              busy,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic              is_pal,
    output logic [ID_W-1:0]   done_id,
    output logic [7:0]        pal_count
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      sh_q, sh_d;
    logic [W-1:0]      hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   win_id;
    logic [W-1:0]      win_word;
    int unsigned       idx;
    logic              last_bit;

    logic [N-1:0]      gnt_d;
    logic              busy_d, ser_out_d, ser_valid_d, done_d, is_pal_d;
    logic [ID_W-1:0]   done_id_d;

    function automatic logic palin(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < int'(W / 2); k++) begin
            if (v[k] != v[W-1-k]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Rotating priority: nearest requester above last_q wins, wrapping
    always_comb begin
        win_id = ID_W'(0);
        idx    = 0;
        for (int i = int'(N); i >= 1; i--) begin
            idx = (int'(last_q) + i) % N;
            if (req[idx]) win_id = ID_W'(idx);
        end
        win_word = data_in[int'(win_id) * W +: W];
    end

    assign last_bit = (cnt_q == CNT_W'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        sh_d        = sh_q;
        hist_d      = hist_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = '0;
        busy_d      = 1'b0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        is_pal_d    = 1'b0;
        done_id_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sh_d          = win_word;
                    last_d        = win_id;
                    cnt_d         = '0;
                    gnt_d[win_id] = 1'b1;
                    busy_d        = 1'b1;
                    ser_valid_d   = 1'b1;
                    ser_out_d     = win_word[W-1];
                end
            end
            SHIFT: begin
                sh_d   = sh_q << 1;
                hist_d = W'({hist_q, sh_q[W-1]});
                busy_d = 1'b1;
                if (last_bit) begin
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    is_pal_d  = palin(hist_d);
                    done_id_d = last_q;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    ser_valid_d = 1'b1;
                    ser_out_d   = sh_d[W-1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q      <= '0;
            hist_q    <= '0;
            cnt_q     <= '0;
            last_q    <= ID_W'(N - 1);
            gnt       <= '0;
            busy      <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            is_pal    <= 1'b0;
            done_id   <= '0;
        end else begin
            sh_q      <= sh_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            ser_out   <= ser_out_d;
            ser_valid <= ser_valid_d;
            done      <= done_d;
            is_pal    <= is_pal_d;
            done_id   <= done_id_d;
        end
    end

`ifdef PALIN_CHK_STATS_EN
    logic [7:0] pal_cnt_q;

    // Saturating count of palindrome results, bumped on the REPORT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_cnt_q <= 8'd0;
        end else if (state_q == REPORT && is_pal && pal_cnt_q != 8'hFF) begin
            pal_cnt_q <= pal_cnt_q + 8'd1;
        end
    end

    assign pal_count = pal_cnt_q;
`else
    assign pal_count = 8'd0;
`endif

endmodule

// File: tb/tb_palin_chk_sched.sv
// Directed self-checking bench for palin_chk_sched (N=4, W=8).
module tb_palin_chk_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic        busy, ser_out, ser_valid, done, is_pal;
    logic [1:0]  done_id;
    logic [7:0]  pal_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int waited;

    palin_chk_sched #(.N(4), .W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .busy(busy), .ser_out(ser_out), .ser_valid(ser_valid),
        .done(done), .is_pal(is_pal), .done_id(done_id), .pal_count(pal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pal_count();
`ifdef PALIN_CHK_STATS_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Issue req, follow one job from grant through REPORT and back to IDLE
    task automatic do_job(input string tag, input logic [3:0] r, input bit drop,
                          input logic [3:0] exp_gnt, input logic [7:0] exp_word,
                          input bit exp_pal, input logic [1:0] exp_id, output int wcnt);
        logic [31:0] saved;
        bit found;
        found = 1'b0;
        wcnt  = 0;
        req   = r;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            wcnt++;
            if (gnt != 4'd0) found = 1'b1;
        end
        if (!found) begin
            check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        if (drop) req = 4'd0;
        saved   = data_in;
        data_in = ~data_in;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
            check({tag, "_ser"}, 32'({ser_valid, busy, ser_out}), 32'({2'b11, exp_word[7-k]}));
            @(negedge clk);
        end
        check({tag, "_done"}, 32'({done, busy, ser_valid}), 32'b110);
        check({tag, "_is_pal"}, 32'(is_pal), 32'(exp_pal));
        check({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
        if (exp_pal) exp_cnt++;
        @(negedge clk);
        check({tag, "_idle"}, 32'({done, busy, ser_valid}), 32'd0);
        check({tag, "_pal_count"}, 32'(pal_count), exp_pal_count());
        data_in = saved;
    endtask

    initial begin
        bit found;
        rst     = 1'b1;
        req     = 4'b1111;
        data_in = {8'hE7, 8'h99, 8'hD2, 8'hB2};
        #15;
        check("rst_outputs", 32'({gnt, busy, ser_valid, done, ser_out, is_pal}), 32'd0);
        check("rst_pal_count", 32'(pal_count), 32'd0);
        @(negedge clk);
        check("rst_gnt_hold", 32'(gnt), 32'd0);
        rst = 1'b0;

        do_job("first", 4'b1111, 1'b1, 4'b0001, 8'hB2, 1'b0, 2'd0, waited);
        do_job("pal", 4'b0100, 1'b1, 4'b0100, 8'b10011001, 1'b1, 2'd2, waited);
        do_job("npal", 4'b0001, 1'b1, 4'b0001, 8'b10110010, 1'b0, 2'd0, waited);

        rst = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        data_in = 32'hFFFF_FFFF;
        for (int j = 0; j < 5; j++) begin
            do_job("rr", 4'b1111, j == 4, 4'(1 << (j % 4)), 8'hFF, 1'b1, 2'(j % 4), waited);
            if (j > 0) check("rr_spacing", 32'(waited), 32'd1);
        end

        data_in = {8'hE7, 8'h99, 8'hD2, 8'hB2};
        req   = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (gnt != 4'd0) found = 1'b1;
        end
        check("mid_gnt_seen", 32'(found), 32'd1);
        req = 4'd0;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", 32'({busy, ser_valid}), 32'b11);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({gnt, busy, ser_valid, done, ser_out}), 32'd0);
        exp_cnt = 0;
        check("mid_rst_pal_count", 32'(pal_count), 32'd0);
        req = 4'b1010;
        @(negedge clk);
        check("mid_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        do_job("mid_after", 4'b1010, 1'b1, 4'b0010, 8'hD2, 1'b0, 2'd1, waited);

        do_job("withdrawn", 4'b1000, 1'b1, 4'b1000, 8'hE7, 1'b1, 2'd3, waited);
        @(negedge clk);
        check("withdrawn_stays_idle", 32'({busy, gnt}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
